bcd_to_binary: RTL

Sequential BCD-to-binary converter. It is the inverse of the display path's binary-to-decimal divider: it takes a packed multi-digit BCD value, such as a count entered or shown on the 4-digit seven-segment display, and returns its binary equivalent. It uses one multiply-by-10-and-add step per clock. The block sits between digit-oriented logic and any binary arithmetic or comparison downstream.

---
 rtl/bcd_to_binary.sv | 101 ++++++++++
 1 files changed

// File: rtl/bcd_to_binary.sv
// Sequential packed-BCD to binary converter: one multiply-by-10-and-add step per
// clock, most significant digit first, with a one-cycle done pulse per result.
module bcd_to_binary #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd,
  output logic [BIN_W-1:0]      binary,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_e;

  state_e              state_q;
  logic [4*DIGITS-1:0] shift_q;
  logic [BIN_W-1:0]    acc_q;
  logic [BIN_W-1:0]    acc_d;
  logic [IDX_W-1:0]    idx_q;
  logic                invalid_q;
  logic [BIN_W-1:0]    binary_q;
  logic                busy_q;
  logic                done_q;
  logic                error_q;
  logic                bcd_bad;

  // NOTE: every always_comb output gets a default before any conditional
  // assignment, otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    bcd_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] > 4'd9) bcd_bad = 1'b1;
    end
  end

  // The digit under conversion always sits in the top nibble of the shifter.
  always_comb begin
    acc_d = (acc_q << 3) + (acc_q << 1) + BIN_W'(shift_q[4*DIGITS-1 -: 4]);
  end

  // NOTE: state is updated with non-blocking assignments only, so every
  // register samples the values from before this edge regardless of order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      acc_q     <= '0;
      idx_q     <= '0;
      invalid_q <= 1'b0;
      binary_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            shift_q   <= bcd;
            acc_q     <= '0;
            idx_q     <= LAST_IDX;
            busy_q    <= 1'b1;
            invalid_q <= bcd_bad;
            state_q   <= bcd_bad ? FINISH : RUN;
          end
        end
        RUN: begin
          acc_q   <= acc_d;
          shift_q <= shift_q << 4;
          idx_q   <= idx_q - 1'b1;
          if (idx_q == '0) state_q <= FINISH;
        end
        FINISH: begin
          binary_q <= invalid_q ? '0 : acc_q;
          error_q  <= invalid_q;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign binary = binary_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign error  = error_q;

endmodule
